gate_truth_table_checker: RTL and testbench
===========================================

// Module: gate_truth_table_checker
// PURPOSE
//  Self-running stimulus/response stage for 2-input logic gates under test (nand_gate etc).
//  Drives a/b through all four input vectors {a,b}=00,01,10,11, holds each for HOLD_CYCLES,
//  samples the gate output c, compares against an expected truth table, reports pass/fail.
//  Sits directly upstream (a,b) and downstream (c) of the gate; used on-board and in lab benches.
// PARAMETERS
//  HOLD_CYCLES  4        cycles each vector is driven before c is sampled; legal range 1..255
//  EXPECTED     4'b0111  expected c per vector, bit index = {a,b}; default = NAND truth table
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  rst       in   1  asynchronous, active-high reset
//  start     in   1  begin a check run; accepted only in IDLE or DONE
//  abort     in   1  synchronous abort; returns to IDLE from any state
//  a         out  1  gate input A (MSB of vector index)
//  b         out  1  gate input B (LSB of vector index)
//  c         in   1  gate output under test
//  busy      out  1  high in DRIVE/SAMPLE
//  done      out  1  high while in DONE (level, not pulse)
//  pass      out  1  valid when done: 1 iff observed == EXPECTED
//  observed  out  4  sampled c per vector, bit index = {a,b}
//  mismatch  out  4  observed ^ EXPECTED, accumulated as vectors are sampled
// BEHAVIOUR
//  Reset: state=IDLE; a=b=0; busy=done=pass=0; observed=mismatch=4'b0000; idx=0; cnt=0.
//  States: IDLE, DRIVE, SAMPLE, DONE.
//  IDLE  : start=1 -> DRIVE; idx<=0, cnt<=0, observed<=0, mismatch<=0.
//  DRIVE : {a,b}={idx}; cnt increments each cycle; when cnt==HOLD_CYCLES-1 -> SAMPLE.
//  SAMPLE: {a,b} unchanged; observed[idx]<=c; mismatch[idx]<=c^EXPECTED[idx];
//          idx==3 -> DONE, else idx<=idx+1, cnt<=0 -> DRIVE.
//  DONE  : done=1; pass=(mismatch==0), computed from final registered values; a,b hold 1,1.
//          start=1 -> restart exactly as from IDLE (observed/mismatch cleared same edge).
//  Latency: start accepted at edge N -> done high from edge N+4*(HOLD_CYCLES+1).
//  Each vector: HOLD_CYCLES DRIVE cycles + 1 SAMPLE cycle; c sampled after >=HOLD_CYCLES
//  cycles of stable a,b, giving gate settle margin.
//  start while busy: ignored, run continues unaffected.
//  abort: highest priority over start; -> IDLE, a=b=0, busy=done=pass=0; observed/mismatch
//  keep their partial values until next start. abort and start same cycle -> IDLE, no start.
//  pass is 0 whenever done=0; never glitches high mid-run.
//  cnt width $clog2(HOLD_CYCLES+1); no wrap possible since cnt clears on each SAMPLE.
//  idx 2 bits; never wraps (DONE entered at idx==3).
//  rst asserted mid-run: immediate return to reset values, no partial result retained.
//  c treated as synchronous to clk (gate is combinational from a,b); no synchroniser inside.
// STRUCTURE
//  Shared header gate_chk_defs.vh: state encodings (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2,
//  DONE=2'd3), NUM_VECTORS=4, NAND_TT=4'b0111, AND_TT=4'b1000, OR_TT=4'b1110, XOR_TT=4'b0110.
//  One sub-module: hold_timer (load/enable counter with terminal-count output, width param),
//  instantiated once for the DRIVE dwell; FSM, idx and result registers in top.
// TESTING
//  1 Correct NAND, HOLD_CYCLES=4: pulse start -> a,b step 00,01,10,11 each 5 cycles;
//    done at start+20; observed=4'b0111, mismatch=0, pass=1.
//  2 Gate replaced by AND, EXPECTED=NAND_TT: -> observed=4'b1000, mismatch=4'b1111, pass=0.
//  3 Stuck-at-1 output (c=1): -> observed=4'b1111, mismatch=4'b1000, pass=0.
//  4 Abort after 7 cycles of run: -> IDLE next edge, a=b=0, busy=0, done=0, observed[0]
//    retained; new start completes normally with pass=1.
//  5 start pulsed at cycles 3 and 10 of a run: ignored, done still at start+20; start in
//    DONE -> done drops next edge, observed/mismatch cleared, second run passes.
//  6 rst asserted asynchronously mid-SAMPLE (between edges): all outputs to reset
//    values immediately; HOLD_CYCLES=1 run afterwards: done at start+8, pass=1.

Source files
------------

// File: rtl/gate_truth_table_checker_pkg.sv
// Shared definitions for the 2-input gate truth-table checker: FSM states,
// vector count, reference truth tables and a small bit-update helper.
package gate_truth_table_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } chk_state_t;

    localparam int NUM_VECTORS = 4;

    // Truth tables indexed by {a,b}
    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;
    localparam logic [3:0] XOR_TT  = 4'b0110;

    // Returns vec with bit sel replaced by val
    function automatic logic [3:0] set_bit(input logic [3:0] vec,
                                           input logic [1:0] sel,
                                           input logic       val);
        logic [3:0] res;
        res      = vec;
        res[sel] = val;
        return res;
    endfunction

endpackage

// File: rtl/gate_truth_table_checker_hold_timer.sv
// Dwell counter: clears on demand, counts while enabled, and flags when the
// count reaches a fixed terminal value.
module gate_truth_table_checker_hold_timer #(
    parameter int WIDTH    = 3,
    parameter int TERMINAL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WIDTH-1:0] count;

    // Count up while enabled; clear has priority so every dwell starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/gate_truth_table_checker.sv
// Self-running stimulus/response stage for a 2-input gate: walks {a,b}
// through 00,01,10,11, samples c after each dwell and compares with EXPECTED.
module gate_truth_table_checker
    import gate_truth_table_checker_pkg::*;
#(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [3:0] EXPECTED    = NAND_TT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] observed,
    output logic [3:0] mismatch
);

    localparam int         CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

    chk_state_t state;
    logic [1:0] idx;
    logic       hold_done;
    logic       timer_clear;
    logic       timer_en;
    logic [3:0] observed_upd;
    logic [3:0] mismatch_upd;

    // The timer only runs in DRIVE and sits at zero otherwise, so every
    // entry into DRIVE starts a fresh dwell of HOLD_CYCLES cycles.
    assign timer_en    = (state == DRIVE);
    assign timer_clear = (state != DRIVE) || abort;

    gate_truth_table_checker_hold_timer #(
        .WIDTH    (CNT_W),
        .TERMINAL (HOLD_CYCLES - 1)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (hold_done)
    );

    // Result vectors as they will look after sampling the current vector
    assign observed_upd = set_bit(observed, idx, c);
    assign mismatch_upd = set_bit(mismatch, idx, c ^ EXPECTED[idx]);

    // Sequencer: abort beats start; pass is only ever set on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 2'd0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            observed <= 4'b0000;
            mismatch <= 4'b0000;
        end else if (abort) begin
            state <= IDLE;
            a     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= DRIVE;
                        idx      <= 2'd0;
                        a        <= 1'b0;
                        b        <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        observed <= 4'b0000;
                        mismatch <= 4'b0000;
                    end
                end
                DRIVE: begin
                    if (hold_done) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    observed <= observed_upd;
                    mismatch <= mismatch_upd;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mismatch_upd == 4'b0000);
                    end else begin
                        state    <= DRIVE;
                        idx      <= idx + 2'd1;
                        {a, b}   <= idx + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Scoreboard bench: two checkers (HOLD_CYCLES 4 and 1) each driving a modelled
// gate; expected results are queued at start and checked when done rises.
module tb_gate_truth_table_checker;
    import gate_truth_table_checker_pkg::*;

    localparam int H4 = 4;
    localparam int H1 = 1;

    typedef enum int {G_NAND, G_AND, G_STUCK1, G_TABLE} gate_mode_t;

    typedef struct {
        logic [3:0] obs;
        logic [3:0] mis;
        logic       pass;
        int         done_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0, abort4 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic a4, b4, c4, busy4, done4, pass4;
    logic a1, b1, c1, busy1, done1, pass1;
    logic [3:0] observed4, mismatch4, observed1, mismatch1;

    gate_mode_t mode4 = G_NAND, mode1 = G_NAND;
    logic [3:0] tt4 = 4'b0000, tt1 = 4'b0000;

    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    logic done4_q = 1'b0, done1_q = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    gate_truth_table_checker #(.HOLD_CYCLES(H4), .EXPECTED(NAND_TT)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4),
        .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
        .observed(observed4), .mismatch(mismatch4)
    );

    gate_truth_table_checker #(.HOLD_CYCLES(H1), .EXPECTED(NAND_TT)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .observed(observed1), .mismatch(mismatch1)
    );

    // Behavioural gate under test
    function automatic logic gate_fn(input gate_mode_t m, input logic [3:0] tt,
                                     input logic ga, input logic gb);
        case (m)
            G_NAND:   return !(ga && gb);
            G_AND:    return ga && gb;
            G_STUCK1: return 1'b1;
            default:  return tt[{ga, gb}];
        endcase
    endfunction

    always_comb c4 = gate_fn(mode4, tt4, a4, b4);
    always_comb c1 = gate_fn(mode1, tt1, a1, b1);

    // Reference: what a full check run of this gate must report
    function automatic exp_t model_run(input gate_mode_t m, input logic [3:0] tt,
                                       input int start_edge, input int hold);
        exp_t r;
        r.obs = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            r.obs[v] = gate_fn(m, tt, v[1], v[0]);
        end
        r.mis       = r.obs ^ NAND_TT;
        r.pass      = (r.obs == NAND_TT);
        r.done_edge = start_edge + 4 * (hold + 1);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse start on one checker and queue the result it must produce
    task automatic applyStimulus(input int sel);
        @(negedge clk);
        if (sel == 4) begin
            start4 = 1'b1;
            q4.push_back(model_run(mode4, tt4, cyc + 1, H4));
        end else begin
            start1 = 1'b1;
            q1.push_back(model_run(mode1, tt1, cyc + 1, H1));
        end
        @(negedge clk);
        start4 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitDone(input int sel);
        int n = 0;
        while (((sel == 4) ? q4.size() : q1.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("run completes in budget",
                    32'((sel == 4) ? q4.size() : q1.size()), 32'd0);
    endtask

    // Monitor for the HOLD_CYCLES=4 checker
    always @(negedge clk) begin
        if (!rst) begin
            if (done4 && !done4_q) begin
                if (q4.size() == 0) begin
                    checkOutput("dut4 unexpected done", 32'd1, 32'd0);
                end else begin
                    e4 = q4.pop_front();
                    checkOutput("dut4 observed", 32'(observed4), 32'(e4.obs));
                    checkOutput("dut4 mismatch", 32'(mismatch4), 32'(e4.mis));
                    checkOutput("dut4 pass", 32'(pass4), 32'(e4.pass));
                    checkOutput("dut4 done edge", cyc, e4.done_edge);
                end
            end
            if (!done4 && pass4) checkOutput("dut4 pass while not done", 32'(pass4), 32'd0);
        end
        done4_q = done4;
    end

    // Monitor for the HOLD_CYCLES=1 checker
    always @(negedge clk) begin
        if (!rst) begin
            if (done1 && !done1_q) begin
                if (q1.size() == 0) begin
                    checkOutput("dut1 unexpected done", 32'd1, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    checkOutput("dut1 observed", 32'(observed1), 32'(e1.obs));
                    checkOutput("dut1 mismatch", 32'(mismatch1), 32'(e1.mis));
                    checkOutput("dut1 pass", 32'(pass1), 32'(e1.pass));
                    checkOutput("dut1 done edge", cyc, e1.done_edge);
                end
            end
            if (!done1 && pass1) checkOutput("dut1 pass while not done", 32'(pass1), 32'd0);
        end
        done1_q = done1;
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset dut4 outputs",
                    32'({a4, b4, busy4, done4, pass4, observed4, mismatch4}), 32'd0);
        checkOutput("reset dut1 outputs",
                    32'({a1, b1, busy1, done1, pass1, observed1, mismatch1}), 32'd0);
        rst = 1'b0;

        // Correct NAND, also track the a,b walk cycle by cycle
        $display("[TB] correct NAND");
        mode4 = G_NAND;
        applyStimulus(4);
        for (int k = 0; k < 4 * (H4 + 1); k++) begin
            checkOutput("dut4 a,b walk", 32'({a4, b4}), 32'(k / (H4 + 1)));
            checkOutput("dut4 busy during run", 32'(busy4), 32'd1);
            @(negedge clk);
        end
        waitDone(4);

        $display("[TB] AND gate against NAND table");
        mode4 = G_AND;
        applyStimulus(4);
        waitDone(4);
        checkOutput("dut4 a,b held in DONE", 32'({a4, b4}), 32'd3);

        $display("[TB] stuck-at-1 output");
        mode4 = G_STUCK1;
        applyStimulus(4);
        waitDone(4);

        // Abort seven cycles into a run
        $display("[TB] abort mid-run");
        mode4 = G_NAND;
        applyStimulus(4);
        repeat (6) @(negedge clk);
        abort4 = 1'b1;
        q4.delete();
        @(negedge clk);
        abort4 = 1'b0;
        checkOutput("abort clears a,b,busy,done,pass",
                    32'({a4, b4, busy4, done4, pass4}), 32'd0);
        checkOutput("abort keeps partial observed", 32'(observed4), 32'b0001);
        checkOutput("abort keeps partial mismatch", 32'(mismatch4), 32'd0);
        applyStimulus(4);
        waitDone(4);

        // Abort and start together: abort wins
        @(negedge clk);
        start4 = 1'b1;
        abort4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        abort4 = 1'b0;
        checkOutput("abort beats start", 32'({busy4, done4}), 32'd0);

        // start while busy is ignored; start in DONE restarts cleanly
        $display("[TB] start while busy and restart from DONE");
        applyStimulus(4);
        repeat (2) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (6) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        waitDone(4);
        checkOutput("dut4 done level held", 32'(done4), 32'd1);
        applyStimulus(4);
        checkOutput("restart drops done", 32'({done4, busy4}), 32'b01);
        checkOutput("restart clears results", 32'({observed4, mismatch4}), 32'd0);
        waitDone(4);

        // Asynchronous reset while sampling the second vector
        $display("[TB] async reset mid-SAMPLE");
        applyStimulus(4);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre-reset in second vector", 32'({a4, b4, busy4}), 32'b011);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async reset dut4 outputs",
                    32'({a4, b4, busy4, done4, pass4, observed4, mismatch4}), 32'd0);
        q4.delete();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mode1 = G_NAND;
        applyStimulus(1);
        waitDone(1);

        // Randomised gate truth tables on both checkers
        $display("[TB] random truth tables");
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                mode4 = G_TABLE;
                tt4   = 4'($urandom_range(0, 15));
                if (i % 4 == 0) tt4 = NAND_TT;
                applyStimulus(4);
                waitDone(4);
            end else begin
                mode1 = G_TABLE;
                tt1   = 4'($urandom_range(0, 15));
                if (i % 4 == 1) tt1 = NAND_TT;
                applyStimulus(1);
                waitDone(1);
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
